// File: rtl/dst7_1d_sched_if.sv
// Requester and result handshake bundle for the dst7_1d core scheduler.
// master = job producer / result consumer side, slave = scheduler side.
interface dst7_1d_sched_if #(
   parameter int XW = 288,
   parameter int YW = 512
);
   logic          req0_valid;
   logic [1:0]    req0_n;
   logic [XW-1:0] req0_x;
   logic          req0_ready;
   logic          req1_valid;
   logic [1:0]    req1_n;
   logic [XW-1:0] req1_x;
   logic          req1_ready;
   logic          out_valid;
   logic          out_id;
   logic [YW-1:0] out_y;
   logic          out_ready;

   modport master (
      output req0_valid, req0_n, req0_x,
      input  req0_ready,
      output req1_valid, req1_n, req1_x,
      input  req1_ready,
      input  out_valid, out_id, out_y,
      output out_ready
   );

   modport slave (
      input  req0_valid, req0_n, req0_x,
      output req0_ready,
      input  req1_valid, req1_n, req1_x,
      output req1_ready,
      output out_valid, out_id, out_y,
      input  out_ready
   );
endinterface

// File: rtl/dst7_1d_sched.sv
// Two-requester scheduler in front of a shared combinational dst7_1d core.
// Define DST7_SCHED_RR_EN for round-robin grant; default is fixed priority (req0 first).
module dst7_1d_sched #(
   parameter int XW = 288,
   parameter int YW = 512
) (
   input  logic           clk,
   input  logic           rst_n,
   dst7_1d_sched_if.slave bus,
   output logic [1:0]     core_n,
   output logic [XW-1:0]  core_x,
   input  logic [YW-1:0]  core_y,
   output logic           busy
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic          grant_s;
   logic          accept_s;
   logic          ready0_s;
   logic          ready1_s;
   logic [1:0]    core_n_r;
   logic [XW-1:0] core_x_r;
   logic [YW-1:0] out_y_r;
   logic          out_valid_r;
   logic          out_id_r;
   logic          busy_r;

`ifdef DST7_SCHED_RR_EN
   logic ptr_r;

   // Round-robin pointer: after an accept, prefer the requester that lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r <= 1'b0;
      end else if (accept_s) begin
         ptr_r <= ~grant_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Grant: pointer decides only on a tie, otherwise the lone requester wins.
   always_comb begin
      if (bus.req0_valid && bus.req1_valid) begin
         grant_s = ptr_r;
      end else begin
         grant_s = ~bus.req0_valid;
      end
   end
`else
   // Grant: fixed priority, requester 0 over requester 1.
   always_comb begin
      if (bus.req0_valid) begin
         grant_s = 1'b0;
      end else begin
         grant_s = 1'b1;
      end
   end
`endif

   // Next-state and ready decode; readies are suppressed while in reset.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      ready0_s = 1'b0;
      ready1_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
               accept_s = 1'b1;
               ready0_s = ~grant_s;
               ready1_s = grant_s;
               state_s  = ST_ISSUE;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_s = ST_RESP;
         end
         ST_RESP: begin
            if (out_valid_r && bus.out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register with busy registered alongside it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_IDLE);
      end
   end

   // Datapath: load core operands on accept, capture the core result one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_n_r    <= 2'd0;
         core_x_r    <= '0;
         out_y_r     <= '0;
         out_valid_r <= 1'b0;
         out_id_r    <= 1'b0;
      end else begin
         if (accept_s) begin
            if (grant_s) begin
               core_n_r <= bus.req1_n;
               core_x_r <= bus.req1_x;
            end else begin
               core_n_r <= bus.req0_n;
               core_x_r <= bus.req0_x;
            end
            out_id_r <= grant_s;
         end
         if (state_r == ST_ISSUE) begin
            out_y_r     <= core_y;
            out_valid_r <= 1'b1;
         end else if ((state_r == ST_RESP) && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.req0_ready = ready0_s;
   assign bus.req1_ready = ready1_s;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_id     = out_id_r;
   assign bus.out_y      = out_y_r;
   assign core_n         = core_n_r;
   assign core_x         = core_x_r;
   assign busy           = busy_r;
endmodule

// File: tb/tb_dst7_1d_sched.sv
// Randomized bench for dst7_1d_sched: a behavioural DST-VII core plus a
// transaction-level model of grant, latency and handshake timing.
module tb_dst7_1d_sched;
   localparam int XW = 288;
   localparam int YW = 512;
`ifdef DST7_SCHED_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      bit            v;
      logic [1:0]    n;
      logic [XW-1:0] x;
   } job_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    core_n;
   logic [XW-1:0] core_x;
   logic [YW-1:0] core_y;
   logic          busy;

   int            coef [4][32][32];
   int            n_chk = 0;
   int            n_err = 0;
   job_t          rq [2];
   bit            m_inflight;
   int            m_age;
   bit            m_id;
   logic [1:0]    m_n;
   logic [XW-1:0] m_x;
   logic [YW-1:0] m_y;
   bit            m_ptr;
   bit            m_clr;
   int            n_done;
   bit            done_ids [$];

   dst7_1d_sched_if #(.XW(XW), .YW(YW)) bus ();

   dst7_1d_sched #(.XW(XW), .YW(YW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .core_n (core_n),
      .core_x (core_x),
      .core_y (core_y),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Reference DST-VII: y[k] = sum_i x[i] * round(128*2/sqrt(2N+1)*sin(pi*(2k+1)(i+1)/(2N+1))) >>> 7
   function automatic logic [YW-1:0] dst7_model(input logic [1:0] n, input logic [XW-1:0] x);
      logic [YW-1:0] y;
      int            pts;
      int            acc;
      y   = '0;
      pts = 4 << n;
      for (int k = 0; k < pts; k++) begin
         acc = 0;
         for (int i = 0; i < pts; i++) begin
            acc += coef[n][k][i] * int'($signed(x[i*9 +: 9]));
         end
         y[k*16 +: 16] = 16'(acc >>> 7);
      end
      return y;
   endfunction

   assign core_y = dst7_model(core_n, core_x);

   task automatic chk(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic new_job(input int k);
      rq[k].v = 1'b1;
      rq[k].n = 2'($urandom_range(0, 3));
      for (int w = 0; w < 9; w++) begin
         rq[k].x[w*32 +: 32] = $urandom();
      end
   endtask

   // One clock: drive inputs, check outputs against the model, then advance the model past the edge.
   task automatic step(input bit rst_in, input bit ordy);
      bit       g;
      bit       any;
      bit [1:0] exp_rdy;
      @(negedge clk);
      rst_n          = rst_in;
      bus.out_ready  = ordy;
      bus.req0_valid = rq[0].v;
      bus.req0_n     = rq[0].n;
      bus.req0_x     = rq[0].x;
      bus.req1_valid = rq[1].v;
      bus.req1_n     = rq[1].n;
      bus.req1_x     = rq[1].x;
      #1;
      any     = rq[0].v | rq[1].v;
      g       = (RR && rq[0].v && rq[1].v) ? m_ptr : ~rq[0].v;
      exp_rdy = 2'b00;
      if (rst_in && !m_inflight && any) exp_rdy[g] = 1'b1;
      chk("req0_ready", YW'(bus.req0_ready), YW'(exp_rdy[0]));
      chk("req1_ready", YW'(bus.req1_ready), YW'(exp_rdy[1]));
      chk("busy", YW'(busy), YW'(m_inflight));
      chk("out_valid", YW'(bus.out_valid), YW'(m_inflight && m_age >= 1));
      if (m_inflight) begin
         chk("core_n", YW'(core_n), YW'(m_n));
         chk("core_x", YW'(core_x), YW'(m_x));
      end
      if (m_inflight && m_age >= 1) begin
         chk("out_id", YW'(bus.out_id), YW'(m_id));
         chk("out_y", bus.out_y, m_y);
      end
      if (m_clr) begin
         chk("rst_out_y", bus.out_y, '0);
         chk("rst_out_id", YW'(bus.out_id), '0);
         chk("rst_core_n", YW'(core_n), '0);
         chk("rst_core_x", YW'(core_x), '0);
         m_clr = 1'b0;
      end
      if (!rst_in) begin
         m_inflight = 1'b0;
         m_ptr      = 1'b0;
         m_clr      = 1'b1;
      end else if (!m_inflight) begin
         if (any) begin
            m_inflight = 1'b1;
            m_age      = 0;
            m_id       = g;
            m_n        = rq[g].n;
            m_x        = rq[g].x;
            m_y        = dst7_model(rq[g].n, rq[g].x);
            m_ptr      = ~g;
            rq[g].v    = 1'b0;
         end
      end else if (m_age >= 1 && ordy) begin
         m_inflight = 1'b0;
         n_done++;
         done_ids.push_back(m_id);
      end else begin
         m_age++;
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 40; c++) begin
         if (!m_inflight && !rq[0].v && !rq[1].v) break;
         step(1'b1, 1'b1);
      end
      chk("drain_idle", YW'(m_inflight), '0);
   endtask

   initial begin
      real r;
      int  base;
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < 32; i++) begin
               r = 256.0 / $sqrt(2.0 * (4 << n) + 1.0) *
                   $sin(3.14159265358979 * (2 * k + 1) * (i + 1) / (2.0 * (4 << n) + 1.0));
               coef[n][k][i] = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         rq[k].v = 1'b0;
         rq[k].n = 2'd0;
         rq[k].x = '0;
      end
      m_inflight = 1'b0; m_age = 0; m_id = 1'b0; m_n = 2'd0; m_x = '0; m_y = '0;
      m_ptr = 1'b0; m_clr = 1'b0; n_done = 0;
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_n = 2'd0; bus.req0_x = '0;
      bus.req1_valid = 1'b0; bus.req1_n = 2'd0; bus.req1_x = '0;
      @(posedge clk);

      // Reset with requests pending: readies must stay low, outputs cleared.
      step(1'b0, 1'b1);
      new_job(0);
      new_job(1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      rq[0].v = 1'b0;
      rq[1].v = 1'b0;
      step(1'b1, 1'b1);

      // Single all-zero 4-point job on req0.
      rq[0].v = 1'b1; rq[0].n = 2'd0; rq[0].x = '0;
      base = n_done;
      for (int c = 0; c < 5; c++) step(1'b1, 1'b1);
      chk("single_cnt", YW'(n_done - base), YW'(1));
      chk("single_id", YW'(done_ids[$]), '0);

      // Golden sweep: 1000 random jobs on req0 with random backpressure.
      base = n_done;
      for (int c = 0; c < 20000 && (n_done - base) < 1000; c++) begin
         if (!rq[0].v && (n_done - base + int'(m_inflight)) < 1000) new_job(0);
         step(1'b1, $urandom_range(0, 3) != 0);
      end
      drain();
      chk("golden_cnt", YW'(n_done - base), YW'(1000));

      // Contention from a fresh pointer: both requesters always valid.
      step(1'b0, 1'b1);
      done_ids.delete();
      base = n_done;
      for (int c = 0; c < 40 && (n_done - base) < 4; c++) begin
         if (!rq[0].v) new_job(0);
         if (!rq[1].v) new_job(1);
         step(1'b1, 1'b1);
      end
      chk("cont_cnt", YW'(n_done - base), YW'(4));
      for (int i = 0; i < 4 && i < done_ids.size(); i++) begin
         chk("cont_id", YW'(done_ids[i]), YW'(RR ? i % 2 : 0));
      end
      rq[0].v = 1'b0;
      rq[1].v = 1'b0;
      drain();

      // Backpressure: hold RESP for 10 cycles with both requesters waiting.
      new_job(0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      new_job(0);
      new_job(1);
      base = n_done;
      for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
      chk("bp_held", YW'(n_done - base), '0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      drain();

      // Reset while in ISSUE drops the job; a following req1 job completes normally.
      new_job(0);
      step(1'b1, 1'b1);
      base = n_done;
      step(1'b0, 1'b1);
      rq[0].v = 1'b0;
      new_job(1);
      for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
      chk("rst_drop_cnt", YW'(n_done - base), YW'(1));
      chk("rst_next_id", YW'(done_ids[$]), YW'(1));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
